sevseg_multi_ctrl: RTL and testbench

//  Avalon-MM slave driving NUM_DIGITS seven-segment digits in parallel; successor to the single 7-bit sevseg export.
//  Per-digit hex-decode or raw-segment mode, per-digit blink with programmable period, 16-level PWM brightness.

---
 rtl/sevseg_multi_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sevseg_multi_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sevseg_multi_ctrl.sv
// rtl/sevseg_multi_ctrl.sv - multi-digit seven-segment controller with blink and PWM dimming
module sevseg_multi_ctrl #(
  parameter int NUM_DIGITS    = 6,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int BLINK_W       = 26,
  parameter int BLINK_DIV_RST = 25000000
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  input  logic [3:0]              avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  output logic [31:0]             avs_readdata,
  output logic [7*NUM_DIGITS-1:0] seg_out
);

  localparam logic [BLINK_W-1:0] BLINK_DIV_INIT = BLINK_W'(BLINK_DIV_RST);
  localparam logic [6:0]         SEG_OFF        = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]         ADDR_CTRL      = 4'd0;
  localparam logic [3:0]         ADDR_RAW       = 4'd1;
  localparam logic [3:0]         ADDR_BLINK     = 4'd2;
  localparam logic [3:0]         ADDR_DIV       = 4'd3;
  localparam logic [3:0]         PWM_LAST       = 4'd14;

  // Register file
  logic                  ctrl_enable;
  logic                  ctrl_blink_en;
  logic [3:0]            ctrl_bright;
  logic [NUM_DIGITS-1:0] raw_mask;
  logic [NUM_DIGITS-1:0] blink_mask;
  logic [BLINK_W-1:0]    blink_div;
  logic [6:0]            digit_reg [NUM_DIGITS];

  // Timing state
  logic [BLINK_W-1:0]    prescaler;
  logic                  blink_phase;
  logic [3:0]            pwm_cnt;

  // Combinational helpers
  logic                  div_write;
  logic                  pwm_lit;
  logic [31:0]           rd_value;
  logic [6:0]            seg_code;
  logic                  digit_shown;
  logic [6:0]            seg_lit;
  logic [7*NUM_DIGITS-1:0] seg_next;
  logic                  unused_wdata_bits;

  assign div_write         = avs_write && (avs_address == ADDR_DIV);
  assign pwm_lit           = (pwm_cnt < ctrl_bright);
  assign unused_wdata_bits = ^avs_writedata;

  // Active-high segment pattern for a hex nibble, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Bus writes land in the register file at the accepting edge; unmapped addresses fall through
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      ctrl_enable   <= 1'b1;
      ctrl_blink_en <= 1'b0;
      ctrl_bright   <= 4'hF;
      raw_mask      <= '0;
      blink_mask    <= '0;
      blink_div     <= BLINK_DIV_INIT;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_reg[i] <= 7'h00;
      end
    end else if (avs_write) begin
      case (avs_address)
        ADDR_CTRL: begin
          ctrl_enable   <= avs_writedata[0];
          ctrl_blink_en <= avs_writedata[1];
          ctrl_bright   <= avs_writedata[7:4];
        end
        ADDR_RAW:   raw_mask   <= avs_writedata[NUM_DIGITS-1:0];
        ADDR_BLINK: blink_mask <= avs_writedata[NUM_DIGITS-1:0];
        ADDR_DIV:   blink_div  <= avs_writedata[BLINK_W-1:0];
        default: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (avs_address == 4'(4 + i)) begin
              digit_reg[i] <= avs_writedata[6:0];
            end
          end
        end
      endcase
    end
  end

  // Blink prescaler: a BLINK_DIV write restarts the period and beats a same-cycle expiry
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      prescaler   <= BLINK_DIV_INIT;
      blink_phase <= 1'b0;
    end else if (div_write) begin
      prescaler   <= avs_writedata[BLINK_W-1:0];
      blink_phase <= 1'b0;
    end else if (prescaler == '0) begin
      prescaler   <= blink_div;
      blink_phase <= (blink_div == '0) ? 1'b0 : ~blink_phase;
    end else begin
      prescaler   <= prescaler - BLINK_W'(1);
    end
  end

  // PWM counter runs 0..14 so bright=15 is always lit and bright=0 never is
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      pwm_cnt <= 4'd0;
    end else if (pwm_cnt == PWM_LAST) begin
      pwm_cnt <= 4'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  // Read mux; unused bits and unmapped words return zero
  always_comb begin
    rd_value = '0;
    case (avs_address)
      ADDR_CTRL:  rd_value = {24'd0, ctrl_bright, 2'b00, ctrl_blink_en, ctrl_enable};
      ADDR_RAW:   rd_value[NUM_DIGITS-1:0] = raw_mask;
      ADDR_BLINK: rd_value[NUM_DIGITS-1:0] = blink_mask;
      ADDR_DIV:   rd_value[BLINK_W-1:0] = blink_div;
      default: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (avs_address == 4'(4 + i)) begin
            rd_value[6:0] = digit_reg[i];
          end
        end
      end
    endcase
  end

  // Read data is registered from the pre-write register values, so read+write returns the old value
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      avs_readdata <= 32'd0;
    end else if (avs_read) begin
      avs_readdata <= rd_value;
    end
  end

  // Per-digit decode, blanking by enable/PWM/blink, then polarity applied last
  always_comb begin
    seg_next    = '0;
    seg_code    = 7'h00;
    digit_shown = 1'b0;
    seg_lit     = 7'h00;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seg_code    = raw_mask[i] ? digit_reg[i] : hex_to_seg(digit_reg[i][3:0]);
      digit_shown = ctrl_enable && pwm_lit && !(ctrl_blink_en && blink_mask[i] && blink_phase);
      seg_lit     = digit_shown ? seg_code : 7'h00;
      seg_next[7*i +: 7] = ACTIVE_LOW ? ~seg_lit : seg_lit;
    end
  end

  // Output register; reset forces every segment off without waiting for a clock
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      seg_out <= {NUM_DIGITS{SEG_OFF}};
    end else begin
      seg_out <= seg_next;
    end
  end

endmodule

// File: tb/tb_sevseg_multi_ctrl.sv
// tb/tb_sevseg_multi_ctrl.sv - randomized self-checking bench for sevseg_multi_ctrl
module tb_sevseg_multi_ctrl;
  localparam int N       = 6;
  localparam int BW      = 26;
  localparam int DIV_RST = 25000000;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     address;
  logic           read;
  logic           write;
  logic [31:0]    wdata;
  logic [31:0]    rdata;
  logic [7*N-1:0] seg;

  always #5 clk = ~clk;

  sevseg_multi_ctrl #(
    .NUM_DIGITS(N), .ACTIVE_LOW(1'b1), .BLINK_W(BW), .BLINK_DIV_RST(DIV_RST)
  ) dut (
    .clk_clk(clk), .reset_reset(rst), .avs_address(address), .avs_read(read),
    .avs_write(write), .avs_writedata(wdata), .avs_readdata(rdata), .seg_out(seg)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Edges since reset release; state after edge m has pwm phase m mod 15
  always @(posedge clk) begin
    if (rst) edge_n <= 0;
    else     edge_n <= edge_n + 1;
  end

  // Shadow of programmed state
  bit          m_en;
  bit          m_blink_en;
  int          m_bright;
  logic [N-1:0] m_raw;
  logic [N-1:0] m_bmask;
  longint      m_div;
  longint      m_div_w;
  logic [6:0]  m_digit [N];
  logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic model_reset();
    m_en = 1; m_blink_en = 0; m_bright = 15; m_raw = '0; m_bmask = '0;
    m_div = DIV_RST; m_div_w = 0;
    for (int i = 0; i < N; i++) m_digit[i] = 7'h00;
  endtask

  function automatic logic [31:0] exp_read(input int a);
    logic [31:0] v;
    v = 32'd0;
    if (a == 0) v = {24'd0, 4'(m_bright), 2'b00, m_blink_en, m_en};
    else if (a == 1) v = 32'(m_raw);
    else if (a == 2) v = 32'(m_bmask);
    else if (a == 3) v = 32'(m_div);
    else if (a >= 4 && a < 4 + N) v = {25'd0, m_digit[a-4]};
    return v;
  endfunction

  // Expected seg_out for the state that exists after edge m
  function automatic logic [7*N-1:0] model_seg(input int m);
    logic [7*N-1:0] r;
    logic [6:0] code;
    bit phase;
    int pc;
    pc = m % 15;
    phase = (m_div == 0) ? 1'b0 : ((((longint'(m) - m_div_w) / (m_div + 1)) % 2) == 1);
    for (int i = 0; i < N; i++) begin
      code = m_raw[i] ? m_digit[i] : hex_tab[m_digit[i][3:0]];
      if (!(m_en && (pc < m_bright) && !(m_blink_en && m_bmask[i] && phase))) code = 7'h00;
      r[7*i +: 7] = ~code;
    end
    return r;
  endfunction

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    address = a; wdata = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
    case (a)
      4'd0: begin m_en = d[0]; m_blink_en = d[1]; m_bright = int'(d[7:4]); end
      4'd1: m_raw = d[N-1:0];
      4'd2: m_bmask = d[N-1:0];
      4'd3: begin m_div = longint'(d[BW-1:0]); m_div_w = edge_n; end
      default: if (int'(a) >= 4 && int'(a) < 4 + N) m_digit[int'(a) - 4] = d[6:0];
    endcase
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] v);
    address = a; read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    v = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] exp_v;
    rst = 1'b1; read = 1'b0; write = 1'b0; address = 4'd0; wdata = 32'd0;
    model_reset();
    #12;
    checks++;
    if (seg !== {N{7'h7F}}) begin errors++; $display("FAIL reset_seg_off got %h want %h", seg, {N{7'h7F}}); end
    checks++;
    if (rdata !== 32'd0) begin errors++; $display("FAIL reset_readdata got %h want 0", rdata); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (seg !== {N{7'h40}}) begin errors++; $display("FAIL reset_digits_zero got %h want %h", seg, {N{7'h40}}); end
    for (int a = 0; a < 6; a++) begin
      exp_v = (a == 0) ? 32'h0F1 : (a == 3) ? 32'(DIV_RST) : 32'd0;
      bus_read(4'(a), v);
      checks++;
      if (v !== exp_v) begin errors++; $display("FAIL reset_reg addr %0d got %h want %h", a, v, exp_v); end
    end
  endtask

  task automatic test_hex_decode();
    logic [31:0] v;
    logic [7*N-1:0] exp_s;
    int a;
    bus_write(4'd4, 32'h0000_000A);
    bus_write(4'd5, 32'h0000_0003);
    for (int c = 0; c < 15; c++) begin
      exp_s = model_seg(edge_n);
      @(posedge clk); #1;
      checks++;
      if (seg !== exp_s) begin errors++; $display("FAIL hex_model cyc %0d got %h want %h", c, seg, exp_s); end
    end
    checks++;
    if (seg[6:0] !== ~7'h77) begin errors++; $display("FAIL hex_digit0_A got %h want %h", seg[6:0], ~7'h77); end
    checks++;
    if (seg[13:7] !== ~7'h4F) begin errors++; $display("FAIL hex_digit1_3 got %h want %h", seg[13:7], ~7'h4F); end
    bus_read(4'd4, v);
    checks++;
    if (v !== 32'h0000_000A) begin errors++; $display("FAIL hex_readback got %h want 0000000a", v); end
    for (int r = 0; r < 8; r++) begin
      a = 4 + int'($urandom_range(0, N - 1));
      bus_write(4'(a), $urandom);
      for (int c = 0; c < 3; c++) begin
        exp_s = model_seg(edge_n);
        @(posedge clk); #1;
        checks++;
        if (seg !== exp_s) begin errors++; $display("FAIL hex_rand r %0d got %h want %h", r, seg, exp_s); end
      end
      bus_read(4'(a), v);
      checks++;
      if (v !== exp_read(a)) begin errors++; $display("FAIL hex_rand_read addr %0d got %h want %h", a, v, exp_read(a)); end
    end
  endtask

  task automatic test_raw_mode();
    logic [31:0] v;
    logic [7*N-1:0] exp_s;
    bus_write(4'd1, 32'h1);
    bus_write(4'd4, 32'h49);
    @(posedge clk); #1;
    checks++;
    if (seg[6:0] !== ~7'h49) begin errors++; $display("FAIL raw_digit0 got %h want %h", seg[6:0], ~7'h49); end
    bus_write(4'hF, $urandom);
    bus_write(4'd10, $urandom);
    bus_write(4'd11, $urandom);
    for (int a = 0; a < 16; a++) begin
      bus_read(4'(a), v);
      checks++;
      if (v !== exp_read(a)) begin errors++; $display("FAIL raw_regmap addr %0d got %h want %h", a, v, exp_read(a)); end
    end
    for (int r = 0; r < 5; r++) begin
      bus_write(4'd1, $urandom);
      bus_write(4'(4 + int'($urandom_range(0, N - 1))), $urandom);
      for (int c = 0; c < 4; c++) begin
        exp_s = model_seg(edge_n);
        @(posedge clk); #1;
        checks++;
        if (seg !== exp_s) begin errors++; $display("FAIL raw_rand r %0d got %h want %h", r, seg, exp_s); end
      end
    end
  endtask

  task automatic test_pwm();
    int brights [3] = '{4, 0, 15};
    int lit;
    int b;
    logic [7*N-1:0] exp_s;
    bus_write(4'd1, 32'h0);
    bus_write(4'd4, 32'h8);
    for (int k = 0; k < 3; k++) begin
      bus_write(4'd0, {24'd0, 4'(brights[k]), 4'b0001});
      lit = 0;
      for (int c = 0; c < 15; c++) begin
        exp_s = model_seg(edge_n);
        @(posedge clk); #1;
        if (seg[6:0] !== 7'h7F) lit++;
        checks++;
        if (seg !== exp_s) begin errors++; $display("FAIL pwm_model bright %0d got %h want %h", brights[k], seg, exp_s); end
      end
      checks++;
      if (lit !== brights[k]) begin errors++; $display("FAIL pwm_lit_count bright %0d got %0d want %0d", brights[k], lit, brights[k]); end
    end
    for (int r = 0; r < 4; r++) begin
      b = int'($urandom_range(0, 15));
      bus_write(4'd0, {24'd0, 4'(b), 3'b000, 1'($urandom_range(0, 1))});
      for (int c = 0; c < 20; c++) begin
        exp_s = model_seg(edge_n);
        @(posedge clk); #1;
        checks++;
        if (seg !== exp_s) begin errors++; $display("FAIL pwm_rand bright %0d got %h want %h", b, seg, exp_s); end
      end
    end
    bus_write(4'd0, 32'h0F1);
  endtask

  task automatic test_blink();
    logic [7*N-1:0] exp_s;
    logic [6:0] p0, p1;
    int t0, t1, dark;
    bus_write(4'd2, 32'h2);
    bus_write(4'd0, 32'h0F3);
    bus_write(4'd3, 32'd9);
    t0 = 0; t1 = 0;
    for (int c = 0; c < 40; c++) begin
      exp_s = model_seg(edge_n);
      @(posedge clk); #1;
      if (c > 0 && seg[6:0] !== p0) t0++;
      if (c > 0 && seg[13:7] !== p1) t1++;
      p0 = seg[6:0]; p1 = seg[13:7];
      checks++;
      if (seg !== exp_s) begin errors++; $display("FAIL blink_model cyc %0d got %h want %h", c, seg, exp_s); end
    end
    checks++;
    if (t1 !== 3) begin errors++; $display("FAIL blink_digit1_toggles got %0d want 3", t1); end
    checks++;
    if (t0 !== 0) begin errors++; $display("FAIL blink_digit0_steady got %0d want 0", t0); end
    bus_write(4'd3, 32'd0);
    dark = 0;
    for (int c = 0; c < 25; c++) begin
      exp_s = model_seg(edge_n);
      @(posedge clk); #1;
      if (seg[13:7] === 7'h7F) dark++;
      checks++;
      if (seg !== exp_s) begin errors++; $display("FAIL blink_div0_model cyc %0d got %h want %h", c, seg, exp_s); end
    end
    checks++;
    if (dark !== 0) begin errors++; $display("FAIL blink_div0_dark got %0d want 0", dark); end
    for (int r = 0; r < 3; r++) begin
      bus_write(4'd2, $urandom);
      bus_write(4'd3, 32'($urandom_range(1, 6)));
      for (int c = 0; c < 29; c++) begin
        if (c == 12) bus_write(4'd0, 32'h0F1);
        if (c == 17) bus_write(4'd0, {24'd0, 4'($urandom_range(8, 15)), 4'b0011});
        exp_s = model_seg(edge_n);
        @(posedge clk); #1;
        checks++;
        if (seg !== exp_s) begin errors++; $display("FAIL blink_rand r %0d cyc %0d got %h want %h", r, c, seg, exp_s); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    logic [31:0] old_v;
    logic [31:0] new_v;
    logic [7*N-1:0] exp_s;
    old_v = exp_read(2);
    new_v = {$urandom} & 32'h3F;
    if (new_v == old_v) new_v = old_v ^ 32'h1;
    address = 4'd2; wdata = new_v; read = 1'b1; write = 1'b1;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    m_bmask = new_v[N-1:0];
    checks++;
    if (rdata !== old_v) begin errors++; $display("FAIL b2b_read_old got %h want %h", rdata, old_v); end
    bus_read(4'd2, v);
    checks++;
    if (v !== new_v) begin errors++; $display("FAIL b2b_read_new got %h want %h", v, new_v); end
    for (int i = 0; i < N; i++) bus_write(4'(4 + i), $urandom);
    for (int c = 0; c < 10; c++) begin
      exp_s = model_seg(edge_n);
      @(posedge clk); #1;
      checks++;
      if (seg !== exp_s) begin errors++; $display("FAIL b2b_model cyc %0d got %h want %h", c, seg, exp_s); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    logic [31:0] exp_v;
    logic [7*N-1:0] exp_s;
    bus_write(4'd2, 32'h3F);
    bus_write(4'd0, 32'h073);
    bus_write(4'd3, 32'd3);
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (seg !== {N{7'h7F}}) begin errors++; $display("FAIL midreset_seg_off got %h want %h", seg, {N{7'h7F}}); end
    checks++;
    if (rdata !== 32'd0) begin errors++; $display("FAIL midreset_readdata got %h want 0", rdata); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int a = 0; a < 4 + N; a++) begin
      exp_v = (a == 0) ? 32'h0F1 : (a == 3) ? 32'(DIV_RST) : 32'd0;
      bus_read(4'(a), v);
      checks++;
      if (v !== exp_v) begin errors++; $display("FAIL midreset_reg addr %0d got %h want %h", a, v, exp_v); end
    end
    for (int c = 0; c < 16; c++) begin
      exp_s = model_seg(edge_n);
      @(posedge clk); #1;
      checks++;
      if (seg !== exp_s) begin errors++; $display("FAIL midreset_model cyc %0d got %h want %h", c, seg, exp_s); end
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL timeout checks %0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_hex_decode();
    test_raw_mode();
    test_pwm();
    test_blink();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
